mem_writeback_stage: RTL

- Back half of the 24-bit pipelined core, from execute to writeback.
- Consumes the execute-stage outputs of the datapath: ALU result, store data, control, destination register. Contains the E->M pipeline register, the data memory, and the M->W pipeline register.
- Drives the writeback signals (resultW, WA3W, regWriteW, PCSrcW) back into the datapath's register file and PC mux.

---
 rtl/mem_writeback_stage.sv | 97 +++++++++
 1 files changed

// File: rtl/mem_writeback_stage.sv
// mem_writeback_stage: E->M register, data memory and M->W register.
module mem_writeback_stage #(
  parameter int DATA_WIDTH     = 24,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_DEPTH      = 256,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      regWriteE,
  input  logic                      PCSrcE,
  input  logic                      memToRegE,
  input  logic                      memWriteE,
  input  logic [REG_ADDR_WIDTH-1:0] WA3E,
  input  logic [ADDR_WIDTH-1:0]     aluRes,
  input  logic [DATA_WIDTH-1:0]     srcB,
  output logic                      regWriteW,
  output logic                      PCSrcW,
  output logic [REG_ADDR_WIDTH-1:0] WA3W,
  output logic [DATA_WIDTH-1:0]     resultW
);
  localparam int AW = $clog2(MEM_DEPTH);
  logic                      reg_write_m_d, reg_write_m_q;
  logic                      pc_src_m_d, pc_src_m_q;
  logic                      mem_to_reg_m_d, mem_to_reg_m_q;
  logic                      mem_write_m_d, mem_write_m_q;
  logic [REG_ADDR_WIDTH-1:0] wa3_m_d, wa3_m_q;
  logic [ADDR_WIDTH-1:0]     alu_out_m_d, alu_out_m_q;
  logic [DATA_WIDTH-1:0]     write_data_m_d, write_data_m_q;
  logic                      reg_write_w_d, reg_write_w_q;
  logic                      pc_src_w_d, pc_src_w_q;
  logic                      mem_to_reg_w_d, mem_to_reg_w_q;
  logic [REG_ADDR_WIDTH-1:0] wa3_w_d, wa3_w_q;
  logic [ADDR_WIDTH-1:0]     alu_out_w_d, alu_out_w_q;
  logic [DATA_WIDTH-1:0]     read_data_w_d, read_data_w_q;
  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
  logic [AW-1:0]             mem_idx;
  logic                      in_range_m;
  logic [DATA_WIDTH-1:0]     read_data_m;
  always_comb begin
    mem_idx        = alu_out_m_q[AW-1:0];
    in_range_m     = (alu_out_m_q >> AW) == '0;
    read_data_m    = in_range_m ? mem[mem_idx] : '0;
    reg_write_m_d  = regWriteE;
    pc_src_m_d     = PCSrcE;
    mem_to_reg_m_d = memToRegE;
    mem_write_m_d  = memWriteE;
    wa3_m_d        = WA3E;
    alu_out_m_d    = aluRes;
    write_data_m_d = srcB;
    reg_write_w_d  = reg_write_m_q;
    pc_src_w_d     = pc_src_m_q;
    mem_to_reg_w_d = mem_to_reg_m_q;
    wa3_w_d        = wa3_m_q;
    alu_out_w_d    = alu_out_m_q;
    read_data_w_d  = read_data_m;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_m_q  <= 1'b0;
      pc_src_m_q     <= 1'b0;
      mem_to_reg_m_q <= 1'b0;
      mem_write_m_q  <= 1'b0;
      wa3_m_q        <= '0;
      alu_out_m_q    <= '0;
      write_data_m_q <= '0;
      reg_write_w_q  <= 1'b0;
      pc_src_w_q     <= 1'b0;
      mem_to_reg_w_q <= 1'b0;
      wa3_w_q        <= '0;
      alu_out_w_q    <= '0;
      read_data_w_q  <= '0;
    end else begin
      reg_write_m_q  <= reg_write_m_d;
      pc_src_m_q     <= pc_src_m_d;
      mem_to_reg_m_q <= mem_to_reg_m_d;
      mem_write_m_q  <= mem_write_m_d;
      wa3_m_q        <= wa3_m_d;
      alu_out_m_q    <= alu_out_m_d;
      write_data_m_q <= write_data_m_d;
      reg_write_w_q  <= reg_write_w_d;
      pc_src_w_q     <= pc_src_w_d;
      mem_to_reg_w_q <= mem_to_reg_w_d;
      wa3_w_q        <= wa3_w_d;
      alu_out_w_q    <= alu_out_w_d;
      read_data_w_q  <= read_data_w_d;
    end
  end
  // mem_write_m_q is cleared asynchronously, so no store can commit while rst is high
  always_ff @(posedge clk) begin
    if (mem_write_m_q && in_range_m) mem[mem_idx] <= write_data_m_q;
  end
  assign regWriteW = reg_write_w_q;
  assign PCSrcW    = pc_src_w_q;
  assign WA3W      = wa3_w_q;
  assign resultW   = mem_to_reg_w_q ? read_data_w_q : DATA_WIDTH'(alu_out_w_q);
endmodule
